// File: rtl/dcache_one_line_pkg.sv
// Shared constants, types and operation decode for the single-line data cache.
// No ports; imported by dcache_one_line.
package dcache_one_line_pkg;

  localparam int ADDR_W         = 32;
  localparam int WORD_W         = 32;
  localparam int LINE_W         = 256;
  localparam int WORDS_PER_LINE = 8;
  localparam int TAG_LSB        = 5;
  localparam int WORD_SEL_MSB   = 4;
  localparam int WORD_SEL_LSB   = 2;

  localparam int TAG_W          = ADDR_W - TAG_LSB;
  localparam int WORD_SEL_W     = WORD_SEL_MSB - WORD_SEL_LSB + 1;
  localparam int BYTES_PER_WORD = WORD_W / 8;

  typedef logic [TAG_W-1:0]                          tag_t;
  typedef logic [WORD_W-1:0]                         word_t;
  typedef logic [WORD_SEL_W-1:0]                     word_sel_t;
  typedef logic [BYTES_PER_WORD-1:0]                 byte_en_t;
  // Word k of the line occupies bits [32k+31:32k] once flattened.
  typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0]     line_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_CMP_RD,
    OP_CMP_WR,
    OP_VICTIM_RD,
    OP_REFILL
  } op_e;

  function automatic op_e decode_op(input logic enable, input logic compare,
                                    input logic read);
    op_e op;
    if (!enable)              op = OP_NONE;
    else if (compare && read) op = OP_CMP_RD;
    else if (compare)         op = OP_CMP_WR;
    else if (read)            op = OP_VICTIM_RD;
    else                      op = OP_REFILL;
    return op;
  endfunction

endpackage

// File: rtl/dcache_one_line.sv
// One cache line: valid/dirty/tag plus eight 32-bit words.
// Ports:
//   clk, rst         - rising-edge clock, async active-high reset
//   enable           - qualifies the operation; low holds state and masks hit/data_out
//   compare, read    - select compare-read/write, victim read or refill
//   address_in       - byte address (tag [31:5], word select [4:2])
//   byte_w_en        - per-byte write enable for compare-write
//   data_in          - compare-write data
//   data_line_in     - refill line
//   hit, data_out    - combinational tag-checked read result
//   dirty, valid     - stored status bits
//   data_line_out    - stored line, address_out - stored line base {tag, 5'b0}
module dcache_one_line
  import dcache_one_line_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              compare,
  input  logic              read,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [3:0]        byte_w_en,
  input  logic [WORD_W-1:0] data_in,
  input  logic [LINE_W-1:0] data_line_in,
  output logic              hit,
  output logic              dirty,
  output logic              valid,
  output logic [WORD_W-1:0] data_out,
  output logic [LINE_W-1:0] data_line_out,
  output logic [ADDR_W-1:0] address_out
);

  // Overlay the enabled bytes of new_w onto old_w.
  function automatic word_t merge_bytes(input word_t old_w, input word_t new_w,
                                        input byte_en_t be);
    word_t r;
    r = old_w;
    for (int b = 0; b < BYTES_PER_WORD; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  logic  valid_q, dirty_q;
  tag_t  tag_q;
  line_t words_q;

  tag_t      req_tag;
  word_sel_t word_sel;
  op_e       op;
  logic      tag_match;
  logic      unused_addr_lsb;

  assign req_tag         = address_in[ADDR_W-1:TAG_LSB];
  assign word_sel        = address_in[WORD_SEL_MSB:WORD_SEL_LSB];
  assign unused_addr_lsb = ^address_in[WORD_SEL_LSB-1:0];
  assign op              = decode_op(enable, compare, read);
  assign tag_match       = (tag_q == req_tag);

  assign hit      = enable & compare & valid_q & tag_match;
  assign data_out = hit ? words_q[word_sel] : '0;

  // Status and line outputs stay live while disabled; the two-way wrapper
  // reads them from the way that is not enabled.
  assign valid         = valid_q;
  assign dirty         = dirty_q;
  assign data_line_out = words_q;
  assign address_out   = {tag_q, {TAG_LSB{1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      tag_q   <= '0;
      words_q <= '0;
    end else begin
      case (op)
        OP_CMP_WR: begin
          // Dirty is set on any write hit, even with no bytes enabled.
          if (hit) begin
            words_q[word_sel] <= merge_bytes(words_q[word_sel], data_in, byte_w_en);
            dirty_q           <= 1'b1;
          end
        end
        OP_REFILL: begin
          words_q <= data_line_in;
          tag_q   <= req_tag;
          valid_q <= 1'b1;
          dirty_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_one_line.sv
module tb_dcache_one_line;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable, compare, read;
  logic [31:0]  address_in;
  logic [3:0]   byte_w_en;
  logic [31:0]  data_in;
  logic [255:0] data_line_in;
  logic         hit, dirty, valid;
  logic [31:0]  data_out;
  logic [255:0] data_line_out;
  logic [31:0]  address_out;

  int total = 0;
  int bad   = 0;

  // Reference model: byte-addressed line storage.
  logic        m_valid, m_dirty;
  logic [26:0] m_tag;
  logic [7:0]  m_bytes [32];

  always #5 clk = ~clk;

  dcache_one_line dut (
    .clk(clk), .rst(rst), .enable(enable), .compare(compare), .read(read),
    .address_in(address_in), .byte_w_en(byte_w_en), .data_in(data_in),
    .data_line_in(data_line_in), .hit(hit), .dirty(dirty), .valid(valid),
    .data_out(data_out), .data_line_out(data_line_out), .address_out(address_out)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_hit();
    return enable && compare && m_valid && (m_tag == address_in[31:5]);
  endfunction

  function automatic logic [31:0] m_word(input int w);
    return {m_bytes[4*w+3], m_bytes[4*w+2], m_bytes[4*w+1], m_bytes[4*w]};
  endfunction

  function automatic logic [255:0] m_line();
    logic [255:0] l;
    for (int k = 0; k < 32; k++) l[8*k +: 8] = m_bytes[k];
    return l;
  endfunction

  task automatic m_clear();
    m_valid = 0; m_dirty = 0; m_tag = '0;
    for (int k = 0; k < 32; k++) m_bytes[k] = 8'h00;
  endtask

  task automatic check_all(input string tag);
    int sel;
    sel = int'(address_in[4:2]);
    chk({tag, ".hit"},   256'(hit),   256'(m_hit()));
    chk({tag, ".dout"},  256'(data_out), 256'(m_hit() ? m_word(sel) : 32'h0));
    chk({tag, ".valid"}, 256'(valid), 256'(m_valid));
    chk({tag, ".dirty"}, 256'(dirty), 256'(m_dirty));
    chk({tag, ".line"},  data_line_out, m_line());
    chk({tag, ".aout"},  256'(address_out), 256'({m_tag, 5'b0}));
  endtask

  task automatic drive(input logic en, input logic cmp, input logic rd,
                       input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] d, input logic [255:0] l);
    enable = en; compare = cmp; read = rd; address_in = a;
    byte_w_en = be; data_in = d; data_line_in = l;
    #2;
  endtask

  // Advance one edge and apply the operation rules to the model.
  task automatic clk_step();
    logic h;
    int   sel;
    h   = m_hit();
    sel = int'(address_in[4:2]);
    @(posedge clk);
    if (!rst && enable) begin
      if (compare && !read && h) begin
        for (int b = 0; b < 4; b++)
          if (byte_w_en[b]) m_bytes[4*sel+b] = data_in[8*b +: 8];
        m_dirty = 1;
      end else if (!compare && !read) begin
        for (int k = 0; k < 32; k++) m_bytes[k] = data_line_in[8*k +: 8];
        m_tag = address_in[31:5]; m_valid = 1; m_dirty = 0;
      end
    end
    #1;
  endtask

  task automatic do_op(input string tag, input logic en, input logic cmp, input logic rd,
                       input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] d, input logic [255:0] l);
    drive(en, cmp, rd, a, be, d, l);
    check_all(tag);
    clk_step();
  endtask

  initial begin
    logic [255:0] line_a, rl;
    logic [26:0]  t;
    m_clear();
    rst = 1;
    drive(1, 1, 1, 32'h0000_0040, 4'h0, 32'h0, '0);
    // Reset state, compare-read at 0x40.
    check_all("reset");
    chk("reset.hit_c", 256'(hit), 256'(0));
    chk("reset.aout_c", 256'(address_out), 256'(0));
    @(negedge clk); rst = 0; #1;

    // Refill 0x1234_5660 with 0xA0+k.
    for (int k = 0; k < 8; k++) line_a[32*k +: 32] = 32'hA0 + k;
    do_op("refill", 1, 0, 0, 32'h1234_5660, 4'h0, 32'h0, line_a);
    drive(1, 1, 1, 32'h1234_566C, 4'h0, 32'h0, '0);
    check_all("rd_a3");
    chk("rd_a3.hit_c",  256'(hit), 256'(1));
    chk("rd_a3.dout_c", 256'(data_out), 256'(32'h0000_00A3));
    chk("rd_a3.aout_c", 256'(address_out), 256'(32'h1234_5660));
    clk_step();

    // Partial byte write.
    do_op("wr_part", 1, 1, 0, 32'h1234_5664, 4'b0101, 32'hDEAD_BEEF, '0);
    drive(1, 1, 1, 32'h1234_5664, 4'h0, 32'h0, '0);
    check_all("rd_part");
    chk("rd_part.dout_c", 256'(data_out), 256'(32'h00AD_00EF));
    chk("rd_part.dirty_c", 256'(dirty), 256'(1));
    clk_step();

    // Write miss, then disabled refill attempt.
    do_op("wr_miss", 1, 1, 0, 32'h9999_9960, 4'hF, 32'h1111_1111, '0);
    do_op("dis", 0, 0, 0, 32'h5555_5540, 4'hF, 32'h0, {8{32'hCAFE_F00D}});
    drive(0, 1, 1, 32'h1234_5664, 4'h0, 32'h0, '0);
    check_all("dis_after");
    chk("dis_after.dout_c", 256'(data_out), 256'(0));
    clk_step();

    // Write hit with no bytes enabled still marks dirty.
    do_op("refill2", 1, 0, 0, 32'h0000_1000, 4'h0, 32'h0, line_a);
    do_op("wr_be0", 1, 1, 0, 32'h0000_1008, 4'h0, 32'hFFFF_FFFF, '0);
    drive(1, 0, 1, 32'h0, 4'h0, 32'h0, '0);
    check_all("victim");
    chk("victim.dirty_c", 256'(dirty), 256'(1));
    clk_step();

    // Async reset with a dirty line and a refill pending.
    drive(1, 0, 0, 32'h7777_7700, 4'h0, 32'h0, {8{32'h1234_ABCD}});
    rst = 1; #1;
    m_clear();
    check_all("rst_async");
    chk("rst_async.line_c", data_line_out, 256'(0));
    clk_step();
    rst = 0; #1;
    check_all("rst_after");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      t = ($urandom_range(0, 2) != 0) ? m_tag : 27'($urandom_range(0, 3));
      for (int k = 0; k < 8; k++) rl[32*k +: 32] = $urandom;
      if ($urandom_range(0, 59) == 0) begin
        drive(1, 0, 0, {t, 5'($urandom)}, 4'($urandom), $urandom, rl);
        rst = 1; #1;
        m_clear();
        check_all("rnd_rst");
        clk_step();
        rst = 0; #1;
      end else begin
        do_op("rnd", 1'($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
              {t, 5'($urandom)}, 4'($urandom), $urandom, rl);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
